// File: rtl/pll_fb_divider.sv
// Programmable integer feedback divider: clk_fb = clk_out / n_active with ceil(N/2) high cycles.
// Latency: clk_fb/fb_pulse register the counter state one clk_out edge after it is decoded.
// No backpressure: en=0 holds the divider idle; div_load is a fire-and-forget strobe.
//
// Ports:
//   clk_out   in   divided clock source (VCO output), the only clock
//   rst_n     in   asynchronous active-low reset
//   en        in   1 = divider runs, 0 = counter and outputs held at zero
//   div_n     in   requested ratio, sampled when div_load=1
//   div_load  in   capture div_n into the shadow ratio register
//   clk_fb    out  divided feedback clock (registered)
//   fb_pulse  out  1-cycle strobe in the clk_out cycle where clk_fb rises
//   n_active  out  ratio currently in effect
//   cfg_err   out  1-cycle strobe: the last div_load requested a ratio below 2
module pll_fb_divider #(
    parameter int CNT_W     = 8,
    parameter int DEFAULT_N = 10
) (
    input  logic             clk_out,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_n,
    input  logic             div_load,
    output logic             clk_fb,
    output logic             fb_pulse,
    output logic [CNT_W-1:0] n_active,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEFAULT_N);
    localparam logic [CNT_W-1:0] MIN_N = CNT_W'(2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow;
    logic             pend;

    logic [CNT_W:0]   half_n;
    logic [CNT_W-1:0] last_cnt;
    logic             wrap;
    logic             boundary;
    logic             div_bad;
    logic [CNT_W-1:0] div_clamped;

    // One extra bit so N = 2**CNT_W-1 does not overflow when rounding up.
    assign half_n      = ({1'b0, n_active} + (CNT_W+1)'(1)) >> 1;
    // n_active never drops below 2, so this subtraction cannot wrap.
    assign last_cnt    = n_active - CNT_W'(1);
    assign wrap        = (cnt == last_cnt);
    // Ratio changes only where a period starts afresh: at the wrap, or while idle.
    assign boundary    = !en || wrap;
    assign div_bad     = (div_n < MIN_N);
    assign div_clamped = div_bad ? MIN_N : div_n;

    // Period counter and decoded outputs.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            clk_fb   <= 1'b0;
            fb_pulse <= 1'b0;
        end else if (en) begin
            clk_fb   <= ({1'b0, cnt} < half_n);
            fb_pulse <= (cnt == '0);
            cnt      <= wrap ? '0 : cnt + CNT_W'(1);
        end else begin
            // Truncating a high phase here is acceptable: the loop is out of lock while idle.
            cnt      <= '0;
            clk_fb   <= 1'b0;
            fb_pulse <= 1'b0;
        end
    end

    // Shadow/pending ratio handling. A load on the same edge as a boundary
    // does not take effect there: the boundary consumes the pre-edge shadow/pend,
    // and the new load re-arms pend for the following boundary.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            n_active <= DEF_N;
            shadow   <= DEF_N;
            pend     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= div_load && div_bad;

            if (boundary && pend) begin
                n_active <= shadow;
            end

            if (div_load) begin
                shadow <= div_clamped;
                pend   <= 1'b1;
            end else if (boundary) begin
                pend   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pll_fb_divider.sv
// Self-checking bench for pll_fb_divider: a per-cycle phase model plus
// directed waveform measurements with hand-computed expectations.
module tb_pll_fb_divider;

    localparam int DEF_N = 10;

    logic       clk_out;
    logic       rst_n;
    logic       en;
    logic [7:0] div_n;
    logic       div_load;
    logic       clk_fb;
    logic       fb_pulse;
    logic [7:0] n_active;
    logic       cfg_err;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    pll_fb_divider #(.CNT_W(8), .DEFAULT_N(DEF_N)) dut (
        .clk_out  (clk_out),
        .rst_n    (rst_n),
        .en       (en),
        .div_n    (div_n),
        .div_load (div_load),
        .clk_fb   (clk_fb),
        .fb_pulse (fb_pulse),
        .n_active (n_active),
        .cfg_err  (cfg_err)
    );

    initial clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    task automatic chk(input string name, input int act, input int exp);
        assert_cnt++;
        if (act != exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_pos = position within the current output period (0..N-1).
    // Within a period the output is high for the first half (rounded up):
    // position p is high iff 2*p < N.
    int m_pos   = 0;
    int m_n     = DEF_N;
    int m_sh    = DEF_N;
    bit m_pend  = 0;
    bit m_fb    = 0;
    bit m_pulse = 0;
    bit m_err   = 0;
    bit m_end;

    always @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_n = DEF_N; m_sh = DEF_N; m_pend = 0;
            m_fb = 0; m_pulse = 0; m_err = 0;
        end else begin
            m_end = !en || ((m_pos + 1) % m_n == 0);
            if (en) begin
                m_fb    = (2 * m_pos < m_n);
                m_pulse = (m_pos == 0);
                m_pos   = (m_pos + 1) % m_n;
            end else begin
                m_fb = 0; m_pulse = 0; m_pos = 0;
            end
            if (m_end && m_pend) begin
                m_n    = m_sh;
                m_pend = 0;
            end
            m_err = div_load && (div_n < 2);
            if (div_load) begin
                m_sh   = (div_n < 2) ? 2 : int'(div_n);
                m_pend = 1;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(posedge clk_out) begin
        #1;
        chk("cyc clk_fb",   int'(clk_fb),   int'(m_fb));
        chk("cyc fb_pulse", int'(fb_pulse), int'(m_pulse));
        chk("cyc n_active", int'(n_active), m_n);
        chk("cyc cfg_err",  int'(cfg_err),  int'(m_err));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int k);
        repeat (k) @(negedge clk_out);
    endtask

    task automatic load(input int v);
        div_n    = 8'(v);
        div_load = 1'b1;
        @(negedge clk_out);
        div_load = 1'b0;
    endtask

    // Wait for the next fb_pulse (possibly the current one), then count the
    // high cycles and total length of that period.
    task automatic measure(input string name, input int exp_hi, input int exp_per);
        int hi, per, guard;
        guard = 0;
        while (!fb_pulse && guard < 600) begin
            @(negedge clk_out);
            guard++;
        end
        chk({name, " pulse seen"}, int'(fb_pulse), 1);
        hi  = 0;
        per = 0;
        do begin
            hi += int'(clk_fb);
            per++;
            @(negedge clk_out);
        end while (!fb_pulse && per < 600);
        chk({name, " high"},   hi,  exp_hi);
        chk({name, " period"}, per, exp_per);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        div_n    = '0;
        div_load = 1'b0;
        cycles(3);

        // Reset state
        chk("rst clk_fb",   int'(clk_fb),   0);
        chk("rst fb_pulse", int'(fb_pulse), 0);
        chk("rst n_active", int'(n_active), 10);
        chk("rst cfg_err",  int'(cfg_err),  0);

        // 1: default N=10 -> 5 high / 5 low
        en    = 1'b1;
        rst_n = 1'b1;
        measure("t1 N10", 5, 10);
        measure("t1 N10 again", 5, 10);

        // 2: load 7 while idle, then run -> 4 high / 3 low
        en = 1'b0;
        cycles(2);
        load(7);
        chk("t2 cfg_err legal", int'(cfg_err), 0);
        cycles(2);
        chk("t2 n_active", int'(n_active), 7);
        en = 1'b1;
        measure("t2 N7", 4, 7);

        // 3: N=10 running, load 4 at cnt=3 -> 10-period finishes, then 2/2
        en = 1'b0;
        load(10);
        cycles(1);
        en = 1'b1;
        measure("t3 N10", 5, 10);
        cycles(2);
        load(4);
        chk("t3 n_active held", int'(n_active), 10);
        measure("t3 N4", 2, 4);
        chk("t3 n_active", int'(n_active), 4);
        measure("t3 N4 again", 2, 4);

        // 4: illegal ratios clamp to 2
        load(1);
        chk("t4 cfg_err div1", int'(cfg_err), 1);
        load(0);
        chk("t4 cfg_err div0", int'(cfg_err), 1);
        cycles(1);
        chk("t4 cfg_err clear", int'(cfg_err), 0);
        cycles(6);
        chk("t4 n_active", int'(n_active), 2);
        measure("t4 N2", 1, 2);

        // 5: drop en during high phase, then re-enable
        en = 1'b0;
        load(10);
        cycles(1);
        en = 1'b1;
        measure("t5 N10", 5, 10);
        cycles(2);
        chk("t5 high before drop", int'(clk_fb), 1);
        en = 1'b0;
        cycles(1);
        chk("t5 clk_fb idle", int'(clk_fb), 0);
        chk("t5 pulse idle",  int'(fb_pulse), 0);
        cycles(3);
        en = 1'b1;
        cycles(1);
        chk("t5 clk_fb rise", int'(clk_fb), 1);
        chk("t5 pulse rise",  int'(fb_pulse), 1);
        measure("t5 fresh period", 5, 10);

        // 6: max ratio 255 -> 128 high / 127 low, then async reset mid-period
        en = 1'b0;
        load(255);
        cycles(1);
        en = 1'b1;
        measure("t6 N255", 128, 255);
        chk("t6 n_active", int'(n_active), 255);
        cycles(50);
        chk("t6 high mid", int'(clk_fb), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async clk_fb",   int'(clk_fb),   0);
        chk("t6 async fb_pulse", int'(fb_pulse), 0);
        chk("t6 async n_active", int'(n_active), 10);
        chk("t6 async cfg_err",  int'(cfg_err),  0);
        @(negedge clk_out);
        rst_n = 1'b1;
        measure("t6 post-reset N10", 5, 10);

        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
